axis_packet_generator: RTL and testbench

AXI4-Stream transmitter that produces bursts of packets from a small command interface (length, count, seed, pattern). It sits upstream of the stream processor and drives its `s_axis_*` slave port. It serves as the on-chip traffic source for bring-up and self-test. It fully honours `tready` backpressure and emits back-to-back packets with no idle cycles between them.

---
 rtl/axis_gen_pkg.sv | 34 +++
 rtl/axis_lfsr32.sv | 37 +++
 rtl/axis_packet_generator.sv | 205 ++++++++++++++++++++
 tb/tb_axis_packet_generator.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/axis_gen_pkg.sv
// axis_gen_pkg
//   Shared definitions for the AXI4-Stream packet generator:
//   - data pattern codes latched from the command interface
//   - FSM state encoding
//   - LFSR polynomial and step/seed helper functions
// Optional feature macro: AXIS_GEN_LFSR_EN (the helpers are harmless when unused).
package axis_gen_pkg;

  localparam logic [1:0] PAT_INC   = 2'b00;
  localparam logic [1:0] PAT_CONST = 2'b01;
  localparam logic [1:0] PAT_LFSR  = 2'b10;

  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  // One step of a right-shifting Galois LFSR: the bit shifted out of bit 0
  // decides whether the polynomial taps are folded back in.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    logic [31:0] shifted;
    shifted = s >> 1;
    return s[0] ? (shifted ^ LFSR_POLY) : shifted;
  endfunction

  // An all-zero LFSR would lock up, so a zero seed becomes 1.
  function automatic logic [31:0] lfsr_fix(input logic [31:0] s);
    return (s == 32'd0) ? 32'd1 : s;
  endfunction

endpackage

// File: rtl/axis_lfsr32.sv
// axis_lfsr32
//   32-bit Galois LFSR used by the packet generator for pattern 10.
//   Built only when AXIS_GEN_LFSR_EN is defined.
//   The register runs one step ahead of the stream: it always holds the word
//   that follows the one currently presented on the bus, so the generator can
//   register it directly into tdata on a handshake.
// Ports:
//   clk    - rising-edge clock
//   areset - asynchronous active-low reset
//   load   - command accepted; loads step(seed) (zero seed replaced by 1)
//   seed   - 32-bit seed (word 0 of the burst)
//   step   - stream handshake; advance one step
//   state  - next word to be sent
`ifdef AXIS_GEN_LFSR_EN
module axis_lfsr32
  import axis_gen_pkg::*;
(
  input  logic        clk,
  input  logic        areset,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        step,
  output logic [31:0] state
);

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state <= 32'd1;
    end else if (load) begin
      state <= lfsr_step(lfsr_fix(seed));
    end else if (step) begin
      state <= lfsr_step(state);
    end
  end

endmodule
`endif

// File: rtl/axis_packet_generator.sv
// axis_packet_generator
//   AXI4-Stream traffic source: on a start command emits pkt_count packets of
//   pkt_len beats each, back to back, honouring tready backpressure.
//   Data patterns: 00 incrementing, 01 constant, 10 LFSR, 11 as 00.
// Optional feature macro: AXIS_GEN_LFSR_EN
//   defined   - pattern 10 uses the axis_lfsr32 sub-module
//   undefined - LFSR compiled out, pattern 10 behaves as incrementing
// Ports:
//   aclk, areset        - clock, asynchronous active-low reset
//   start               - command strobe, sampled only in IDLE
//   pkt_len, pkt_count  - beats per packet, packets per burst
//   pattern, seed       - data pattern select and first word / LFSR seed
//   busy, done          - burst in progress, one-cycle completion pulse
//   beat_count          - saturating count of accepted beats since start
//   m_axis_*            - AXI4-Stream master; all outputs registered
module axis_packet_generator
  import axis_gen_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    start,
  input  logic [LEN_WIDTH-1:0]    pkt_len,
  input  logic [CNT_WIDTH-1:0]    pkt_count,
  input  logic [1:0]              pattern,
  input  logic [DATA_WIDTH-1:0]   seed,
  output logic                    busy,
  output logic                    done,
  output logic [31:0]             beat_count,
  output logic                    m_axis_tvalid,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic [DATA_WIDTH/8-1:0] m_axis_tstrb,
  output logic                    m_axis_tlast,
  input  logic                    m_axis_tready
);

  state_t                  state_reg, state_next;
  logic [LEN_WIDTH-1:0]    len_reg, len_next;
  logic [1:0]              pat_reg, pat_next;
  logic [LEN_WIDTH-1:0]    idx_reg, idx_next;     // beat index within packet
  logic [CNT_WIDTH-1:0]    left_reg, left_next;   // packets remaining incl. current
  logic [DATA_WIDTH-1:0]   data_reg, data_next;
  logic                    valid_reg, valid_next;
  logic                    last_reg, last_next;
  logic                    busy_reg, busy_next;
  logic                    done_reg, done_next;
  logic [31:0]             cnt_reg, cnt_next;
  logic [DATA_WIDTH/8-1:0] keep_reg;

  logic                    hs;
  logic [31:0]             lfsr_ahead;
  logic                    lfsr_sel_in;
  logic                    lfsr_sel;
  logic [DATA_WIDTH-1:0]   word0;
  logic [DATA_WIDTH-1:0]   word_next;

  assign hs = valid_reg & m_axis_tready;

`ifdef AXIS_GEN_LFSR_EN
  localparam bit LFSR_EN = 1'b1;

  axis_lfsr32 u_lfsr (
    .clk    (aclk),
    .areset (areset),
    .load   ((state_reg == ST_IDLE) && start && (pkt_len != '0) && (pkt_count != '0)),
    .seed   (seed[31:0]),
    .step   (hs),
    .state  (lfsr_ahead)
  );
`else
  localparam bit LFSR_EN = 1'b0;

  assign lfsr_ahead = 32'd0;
`endif

  assign lfsr_sel_in = LFSR_EN && (pattern == PAT_LFSR);
  assign lfsr_sel    = LFSR_EN && (pat_reg == PAT_LFSR);

  // First word of the burst comes straight from the command inputs.
  assign word0 = lfsr_sel_in ? DATA_WIDTH'(lfsr_fix(seed[31:0])) : seed;

  // Word following the current one. Reserved pattern 11 (and 10 without
  // the LFSR) falls through to incrementing.
  always_comb begin
    word_next = data_reg + DATA_WIDTH'(1);
    if (pat_reg == PAT_CONST) begin
      word_next = data_reg;
    end else if (lfsr_sel) begin
      word_next = DATA_WIDTH'(lfsr_ahead);
    end
  end

  always_comb begin
    state_next = state_reg;
    len_next   = len_reg;
    pat_next   = pat_reg;
    idx_next   = idx_reg;
    left_next  = left_reg;
    data_next  = data_reg;
    valid_next = valid_reg;
    last_next  = last_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;
    cnt_next   = cnt_reg;

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          cnt_next = 32'd0;
          if ((pkt_len != '0) && (pkt_count != '0)) begin
            state_next = ST_SEND;
            len_next   = pkt_len;
            pat_next   = pattern;
            idx_next   = '0;
            left_next  = pkt_count;
            data_next  = word0;
            valid_next = 1'b1;
            last_next  = (pkt_len == LEN_WIDTH'(1));
            busy_next  = 1'b1;
          end else begin
            // Degenerate command: complete immediately with no beats.
            state_next = ST_FIN;
            done_next  = 1'b1;
          end
        end
      end

      ST_SEND: begin
        if (hs) begin
          cnt_next  = (cnt_reg == 32'hFFFF_FFFF) ? cnt_reg : cnt_reg + 32'd1;
          data_next = word_next;
          if (last_reg) begin
            if (left_reg != CNT_WIDTH'(1)) begin
              left_next = left_reg - CNT_WIDTH'(1);
              idx_next  = '0;
              last_next = (len_reg == LEN_WIDTH'(1));
            end else begin
              state_next = ST_FIN;
              valid_next = 1'b0;
              last_next  = 1'b0;
              busy_next  = 1'b0;
              done_next  = 1'b1;
            end
          end else begin
            idx_next  = idx_reg + LEN_WIDTH'(1);
            // tlast is registered, so look one beat ahead.
            last_next = ((idx_reg + LEN_WIDTH'(2)) == len_reg);
          end
        end
      end

      ST_FIN: begin
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge areset) begin
    if (!areset) begin
      state_reg <= ST_IDLE;
      len_reg   <= '0;
      pat_reg   <= PAT_INC;
      idx_reg   <= '0;
      left_reg  <= '0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
      last_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      cnt_reg   <= 32'd0;
      keep_reg  <= '0;
    end else begin
      state_reg <= state_next;
      len_reg   <= len_next;
      pat_reg   <= pat_next;
      idx_reg   <= idx_next;
      left_reg  <= left_next;
      data_reg  <= data_next;
      valid_reg <= valid_next;
      last_reg  <= last_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      cnt_reg   <= cnt_next;
      keep_reg  <= '1;
    end
  end

  assign busy          = busy_reg;
  assign done          = done_reg;
  assign beat_count    = cnt_reg;
  assign m_axis_tvalid = valid_reg;
  assign m_axis_tdata  = data_reg;
  assign m_axis_tlast  = last_reg;
  assign m_axis_tkeep  = keep_reg;
  assign m_axis_tstrb  = keep_reg;

endmodule

// File: tb/tb_axis_packet_generator.sv
// tb_axis_packet_generator
//   Directed bench for axis_packet_generator. Expected beats are pushed to a
//   scoreboard queue when a command is issued and popped by a monitor at
//   every handshake. Honours AXIS_GEN_LFSR_EN for the pattern-10 expectations.
module tb_axis_packet_generator;

  localparam int DW = 32;
  localparam int LW = 16;
  localparam int CW = 16;

`ifdef AXIS_GEN_LFSR_EN
  localparam bit LFSR_ON = 1'b1;
`else
  localparam bit LFSR_ON = 1'b0;
`endif

  logic            aclk = 1'b0;
  logic            areset = 1'b0;
  logic            start = 1'b0;
  logic [LW-1:0]   pkt_len = '0;
  logic [CW-1:0]   pkt_count = '0;
  logic [1:0]      pattern = 2'b00;
  logic [DW-1:0]   seed = '0;
  logic            busy;
  logic            done;
  logic [31:0]     beat_count;
  logic            m_axis_tvalid;
  logic [DW-1:0]   m_axis_tdata;
  logic [DW/8-1:0] m_axis_tkeep;
  logic [DW/8-1:0] m_axis_tstrb;
  logic            m_axis_tlast;
  logic            m_axis_tready = 1'b0;

  int errors = 0;
  int checks = 0;

  logic [DW:0] exp_q[$];
  logic [DW:0] exp_e;
  logic [DW:0] held;
  logic        stall_prev = 1'b0;
  bit          mon_en = 1'b0;

  always #5 aclk = ~aclk;

  axis_packet_generator #(
    .DATA_WIDTH (DW),
    .LEN_WIDTH  (LW),
    .CNT_WIDTH  (CW)
  ) dut (
    .aclk          (aclk),
    .areset        (areset),
    .start         (start),
    .pkt_len       (pkt_len),
    .pkt_count     (pkt_count),
    .pattern       (pattern),
    .seed          (seed),
    .busy          (busy),
    .done          (done),
    .beat_count    (beat_count),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tstrb  (m_axis_tstrb),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_next(input logic [31:0] w, input logic [1:0] pat);
    logic [31:0] r;
    if (pat == 2'b01) begin
      r = w;
    end else if (pat == 2'b10 && LFSR_ON) begin
      r = w >> 1;
      if (w[0]) r = r ^ 32'h8020_0003;
    end else begin
      r = w + 32'd1;
    end
    return r;
  endfunction

  // Monitor: handshakes resolve on the next rising edge; sample at the falling edge.
  always @(negedge aclk) begin
    if (!areset || !mon_en) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", m_axis_tvalid, 1);
        check("stall_data", m_axis_tdata, held[DW-1:0]);
        check("stall_last", m_axis_tlast, held[DW]);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", exp_q.size(), 1);
        end else begin
          exp_e = exp_q.pop_front();
          check("beat_data", m_axis_tdata, exp_e[DW-1:0]);
          check("beat_last", m_axis_tlast, exp_e[DW]);
          check("beat_keep", m_axis_tkeep, 4'hF);
          check("beat_strb", m_axis_tstrb, 4'hF);
        end
      end
      stall_prev = m_axis_tvalid && !m_axis_tready;
      held = {m_axis_tlast, m_axis_tdata};
    end
  end

  task automatic run_burst(input string name, input int len, input int cnt,
                           input logic [1:0] pat, input logic [31:0] sd,
                           input bit bp, input bit poke);
    int total;
    int cyc;
    int done_cyc;
    logic [31:0] w;
    total = len * cnt;
    w = sd;
    if (pat == 2'b10 && LFSR_ON && w == 32'd0) w = 32'd1;
    for (int k = 0; k < total; k++) begin
      exp_q.push_back({1'((k % len) == len - 1), w});
      w = model_next(w, pat);
    end
    @(posedge aclk); #1;
    start = 1'b1;
    pkt_len = LW'(len);
    pkt_count = CW'(cnt);
    pattern = pat;
    seed = sd;
    m_axis_tready = 1'b1;
    done_cyc = -1;
    cyc = 0;
    while (cyc < 300 && done_cyc < 0) begin
      @(posedge aclk); #1;
      cyc++;
      start = poke && (cyc == 2);
      if (poke) begin
        pkt_len = LW'(1);
        pkt_count = CW'(1);
        pattern = 2'b01;
        seed = 32'h5555_AAAA;
      end
      m_axis_tready = bp ? (((cyc - 1) % 3) == 0) : 1'b1;
      if (cyc == 1 && total > 0) begin
        check({name, "_busy1"}, busy, 1);
        check({name, "_valid1"}, m_axis_tvalid, 1);
      end
      if (done) done_cyc = cyc;
    end
    check({name, "_done"}, done, 1);
    if (!bp) check({name, "_done_cycle"}, done_cyc, total + 1);
    check({name, "_busy_fin"}, busy, 0);
    check({name, "_valid_fin"}, m_axis_tvalid, 0);
    check({name, "_beat_count"}, beat_count, total);
    check({name, "_queue_left"}, exp_q.size(), 0);
    exp_q.delete();
    m_axis_tready = 1'b1;
    @(posedge aclk); #1;
    check({name, "_done_pulse"}, done, 0);
    $display("burst %s len=%0d count=%0d pattern=%0d seed=%08h done_cycle=%0d beats=%0d",
             name, len, cnt, pat, sd, done_cyc, beat_count);
  endtask

  initial begin
    bit seen_done;
    bit seen_valid;

    // Reset state
    areset = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tlast", m_axis_tlast, 0);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_tkeep", m_axis_tkeep, 0);
    check("rst_tstrb", m_axis_tstrb, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_beat_count", beat_count, 0);
    areset = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(posedge aclk);

    run_burst("inc_b2b", 3, 2, 2'b00, 32'hDEAD_BEEF, 1'b0, 1'b0);
    run_burst("inc_bp", 3, 2, 2'b00, 32'hDEAD_BEEF, 1'b1, 1'b0);
    run_burst("single", 1, 4, 2'b01, 32'h1234_5678, 1'b0, 1'b0);
    run_burst("zero_len", 0, 3, 2'b00, 32'h0000_00AA, 1'b0, 1'b0);
    run_burst("zero_cnt", 3, 0, 2'b00, 32'h0000_00AA, 1'b0, 1'b0);
    run_burst("lfsr", 3, 1, 2'b10, 32'h0000_0001, 1'b0, 1'b0);
    run_burst("lfsr_zero", 2, 1, 2'b10, 32'h0000_0000, 1'b0, 1'b0);
    run_burst("rsvd_wrap", 2, 1, 2'b11, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_burst("start_ignored", 3, 2, 2'b00, 32'h0000_0100, 1'b0, 1'b1);

    // Reset mid-burst: manual checks, scoreboard off
    mon_en = 1'b0;
    @(posedge aclk); #1;
    start = 1'b1;
    pkt_len = LW'(4);
    pkt_count = CW'(2);
    pattern = 2'b00;
    seed = 32'h0000_00A0;
    m_axis_tready = 1'b1;
    @(posedge aclk); #1;
    start = 1'b0;
    check("midrst_beat0", m_axis_tdata, 32'hA0);
    @(posedge aclk); #1;
    check("midrst_beat1", m_axis_tdata, 32'hA1);
    @(posedge aclk); #1;
    check("midrst_beat2", m_axis_tdata, 32'hA2);
    areset = 1'b0;
    #1;
    check("midrst_tvalid", m_axis_tvalid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_tlast", m_axis_tlast, 0);
    check("midrst_beat_count", beat_count, 0);
    repeat (2) @(posedge aclk);
    #1;
    areset = 1'b1;
    seen_done = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge aclk); #1;
      if (done === 1'b1) seen_done = 1'b1;
      if (m_axis_tvalid === 1'b1) seen_valid = 1'b1;
    end
    check("midrst_no_done", seen_done, 0);
    check("midrst_no_valid", seen_valid, 0);
    $display("burst midrst truncated beat_count=%0d done_seen=%0d", beat_count, seen_done);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
